// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions used by the encoder, scrambler and TX gearbox.
package pcs_pkg;

   localparam int HEAD_W     = 2;
   localparam int BLOCK_W    = 66;
   localparam int GB_SEQ_MAX = 32;
   localparam int GB_SEQ_W   = 6;

   // Sync headers as they appear on the wire, bit 0 first.
   localparam logic [HEAD_W-1:0] SYNC_DATA = 2'b10;
   localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b01;

   typedef enum logic [1:0] {
      GB_HEAD  = 2'd0,
      GB_DATA  = 2'd1,
      GB_STALL = 2'd2
   } gb_phase_e;

   // Residue bits held in the gearbox for a given sequence position.
   function automatic logic [GB_SEQ_W-1:0] gb_fill(input logic [GB_SEQ_W-1:0] seq);
      return seq + GB_SEQ_W'(seq[0]);
   endfunction

endpackage

// File: rtl/pcs_tx_gearbox.sv
// 66b -> 32b TX gearbox: packs sync header + two payload words into a continuous
// 32-bit stream, stalling upstream for one cycle every 33 output words.
module pcs_tx_gearbox
   import pcs_pkg::*;
#(
   parameter int LEN = 32
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic                valid_i,
   input  logic [HEAD_W-1:0]   head_i,
   input  logic [LEN-1:0]      data_i,
   output logic                ready_o,
   output logic                valid_o,
   output logic [LEN-1:0]      data_o
);

   logic [GB_SEQ_W-1:0] r_seq;
   logic [LEN-1:0]      r_buf;
   logic [LEN-1:0]      r_data;
   logic                r_valid;

   gb_phase_e           w_phase;
   logic [GB_SEQ_W-1:0] w_fill;
   logic [2*LEN-1:0]    w_word;
   logic [2*LEN-1:0]    w_stream;
   logic                w_accept;
   logic                w_advance;

   // The new word lands just above the residue; fill + 34 never exceeds 64 bits,
   // so a 64-bit stream holds everything and the upper half is the next residue.
   always_comb begin
      w_phase  = GB_DATA;
      w_fill   = gb_fill(r_seq);
      w_word   = '0;
      w_stream = '0;
      if (r_seq == GB_SEQ_W'(GB_SEQ_MAX)) begin
         w_phase = GB_STALL;
      end else if (!r_seq[0]) begin
         w_phase = GB_HEAD;
      end
      case (w_phase)
         GB_HEAD:  w_word = {{(LEN-HEAD_W){1'b0}}, data_i, head_i};
         GB_DATA:  w_word = {{LEN{1'b0}}, data_i};
         default:  w_word = '0;
      endcase
      w_stream = (w_word << w_fill) | {{LEN{1'b0}}, r_buf};
   end

   assign ready_o   = (r_seq != GB_SEQ_W'(GB_SEQ_MAX));
   assign w_accept  = valid_i & ready_o;
   assign w_advance = w_accept | (w_phase == GB_STALL);

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_seq   <= '0;
         r_buf   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_advance;
         if (w_advance) begin
            r_data <= w_stream[LEN-1:0];
            r_buf  <= w_stream[2*LEN-1:LEN];
            r_seq  <= (w_phase == GB_STALL) ? '0 : r_seq + 1'b1;
         end
      end
   end

   assign valid_o = r_valid;
   assign data_o  = r_data;

endmodule

// File: doc/pcs_tx_gearbox.md
Name: pcs_tx_gearbox

Overview:
- TX gearbox between the 64b/66b scrambler and the 32-bit SerDes/PMA interface.
- Accepts one 66-bit block as two 32-bit scrambled payload words plus a 2-bit sync header (header bypasses the scrambler).
- Repacks the 66-bit stream into a continuous 32-bit output stream.
- Every 33 output cycles it consumes 32 input words and stalls the upstream path for one cycle via ready_o.

Parameters:
- LEN, 32: payload/output word width in bits; only 32 is supported.
- HEAD_W, 2: sync header width; fixed.

Ports:
- clk  input  1  clock.
- nreset  input  1  synchronous, active-low reset.
- valid_i  input  1  upstream word valid; must also drive the scrambler's valid_i as (valid_i & ready_o).
- head_i  input  2  sync header; sampled only on header cycles (even seq); bit 0 is transmitted first.
- data_i  input  32  scrambled payload word; bit 0 is transmitted first.
- ready_o  output  1  gearbox can accept a word this cycle.
- valid_o  output  1  data_o holds a valid output word.
- data_o  output  32  gearboxed word; bit 0 is transmitted first.

Behaviour:
- State:
  - seq: 6-bit counter, 0..32.
  - buf: 32-bit residue register, LSB is the oldest bit.
  - Residue fill level = seq rounded up to even, derived from seq with no separate counter.
- ready_o = (seq != 32). Combinational from seq only, no dependence on valid_i.
- Accept = valid_i & ready_o.
- Even seq (0,2..30), header cycle:
  - stream = {data_i, head_i, buf[fill-1:0]}.
  - Registered data_o <= stream[31:0].
  - buf <= remaining fill+2 bits.
- Odd seq (1..31), second payload word:
  - stream = {data_i, buf[fill-1:0]}.
  - Registered data_o <= stream[31:0].
  - buf <= remaining fill bits.
- seq 32, stall cycle:
  - buf holds exactly 32 bits; data_o <= buf; buf cleared; no input is consumed.
  - valid_i is ignored that cycle; upstream must hold its word.
- seq advance: on accept or at seq==32. seq 32 wraps to 0. Otherwise seq and buf hold.
- valid_o <= accept | (seq==32). Output latency is 1 cycle from the accepted word.
- Bubbles: valid_i low on a non-stall cycle means no state change and valid_o=0 next cycle. The concatenated valid output stream must be identical with or without bubbles.
- Header alignment: the first word accepted after reset is treated as a header word. Upstream guarantees pairs (word0 with header, then word1).
- Reset, synchronous, also valid mid-block and mid-period:
  - seq=0, buf=0, data_o=0, valid_o=0.
  - ready_o=1 from the first cycle after reset.
  - Partially accumulated bits are discarded; no residual output.
- valid_i during reset is ignored.
- Unused buf bits above the fill level must be zero. Verification checks this.
- Width rules: fill never exceeds 32. Output select is a 0..32-bit shift on a 66-bit concatenation; no wider datapath is needed.

Decomposition:
- Shared package pcs_pkg:
  - HEAD_W=2, BLOCK_W=66, GB_SEQ_MAX=32, GB_SEQ_W=6.
  - SYNC_DATA=2'b10 and SYNC_CTRL=2'b01 (bit 0 first on the wire).
- The scrambler and the encoder use the same package.
- Single module; no sub-module is natural. The shift/select is a local combinational block inside.

Test Plan:
1. Hold nreset low 2 cycles -> valid_o=0, data_o=32'h0, ready_o=1. First accepted word is treated as a header cycle.
2. Header and pair:
   - head_i=2'b10 with data_i=32'hFFFF_FFFF, then data_i=32'h0000_0000 -> data_o=32'hFFFF_FFFE then 32'h0000_0003, valid_o=1 each.
3. Continuous valid_i for 32 words -> ready_o=0 exactly on the 33rd cycle (seq 32).
   - Next cycle valid_o=1 with data_o equal to the residue (all-ones if every payload is 32'hFFFF_FFFF and head 2'b11).
   - ready_o returns to 1 the following cycle.
4. Drop valid_i for 3 cycles at seq 5 -> valid_o=0 for those 3 output slots. seq holds at 5. The concatenated valid output bits match the bubble-free run.
5. Reset pulsed at seq 17 with nonzero buf -> next cycle seq=0, valid_o=0, ready_o=1. A new block (head 2'b01, data 32'hA5A5_A5A5) yields data_o=32'h9696_9695.
6. Random head/data over 3 full 33-cycle periods with random bubbles -> concatenated valid data_o bitstream equals concatenated {data1,data0,head} per block, LSB first. ready_o low exactly once per 33 advancing cycles.
